instruction_encoder: RTL and testbench

Packs operation/operand fields into 32-bit Lapido instruction words and buffers them for the control unit's instruction input. It uses the same class/function bit layout that the control unit decodes, so it is the encoding end of that interface. It serves test sequencers, program loaders and debug injectors that supply instructions to the datapath. It has a ready/valid request port, an encode stage, a DEPTH-entry FIFO and a ready/valid instruction output.

---
 rtl/instruction_encoder.sv | 116 +++++++++++
 tb/tb_instruction_encoder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_encoder.sv
// Encodes operation/operand requests into 32-bit Lapido instruction words and
// queues them in a DEPTH-entry circular FIFO for the control unit.
module instruction_encoder #(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               kind,
    input  logic [4:0]               alu_func,
    input  logic [3:0]               rd,
    input  logic [3:0]               ra,
    input  logic [3:0]               rb,
    input  logic [15:0]              imm,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instr,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     err,
    output logic [7:0]               err_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    // Handshake: a request moves when in_valid && in_ready, an instruction
    // moves when out_valid && out_ready; both may happen in the same cycle.

    logic [31:0]      mem_q [DEPTH];
    logic [31:0]      mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             err_q, err_d;
    logic [7:0]       err_count_q, err_count_d;

    logic [31:0] enc_word;
    logic        enc_legal;
    logic        accept;
    logic        push;
    logic        pop;

    function automatic logic alu_func_legal(input logic [4:0] f);
        case (f)
            5'b00000, 5'b00001, 5'b00011, 5'b00100,
            5'b00101, 5'b00110, 5'b01000, 5'b01001: alu_func_legal = 1'b1;
            default:                                alu_func_legal = f[4];
        endcase
    endfunction

    always_comb begin
        enc_word  = 32'h0;
        enc_legal = 1'b1;
        case (kind)
            3'd0: begin
                enc_word  = {3'b001, alu_func, rd, ra, rb, 12'h000};
                enc_legal = alu_func_legal(alu_func);
            end
            3'd1:    enc_word = {3'b100, 5'b00000, rd, ra, imm};
            3'd2:    enc_word = {3'b100, 5'b00001, rd, ra, imm};
            3'd3:    enc_word = {3'b010, 5'b00010, rd, 4'h0, imm};
            3'd4:    enc_word = 32'h0;
            3'd5:    enc_word = {3'b101, 5'b00100, ra, rb, imm};
            default: enc_legal = 1'b0;
        endcase
    end

    // in_ready ignores out_ready, so a full FIFO refuses requests even while popping.
    assign in_ready  = (level_q != LVL_W'(DEPTH));
    assign out_valid = (level_q != '0);
    assign out_instr = out_valid ? mem_q[rd_ptr_q] : 32'h0;
    assign level     = level_q;
    assign err       = err_q;
    assign err_count = err_count_q;

    assign accept = in_valid && in_ready;
    assign push   = accept && enc_legal;
    assign pop    = out_valid && out_ready;

    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = enc_word;
        end
        wr_ptr_d    = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d    = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        level_d     = level_q + LVL_W'(push) - LVL_W'(pop);
        err_d       = accept && !enc_legal;
        err_count_d = err_count_q;
        if (accept && !enc_legal && err_count_q != 8'hFF) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'h0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            err_q       <= 1'b0;
            err_count_q <= 8'h0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
        end
    end

endmodule

// File: tb/tb_instruction_encoder.sv
// Scoreboard bench for instruction_encoder: expected words queued at accept,
// compared whenever the DUT pops an instruction.
module tb_instruction_encoder;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  kind = 3'd4;
    logic [4:0]  alu_func = 5'd0;
    logic [3:0]  rd = 4'd0;
    logic [3:0]  ra = 4'd0;
    logic [3:0]  rb = 4'd0;
    logic [15:0] imm = 16'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [$clog2(DEPTH):0] level;
    logic        err;
    logic [7:0]  err_count;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    bit stream_done;
    bit fifth_done;

    always #5 clock = ~clock;

    instruction_encoder #(.DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .kind(kind), .alu_func(alu_func), .rd(rd), .ra(ra), .rb(rb), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .level(level), .err(err), .err_count(err_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] alu_word(input logic [4:0] f, input logic [3:0] d,
                                             input logic [3:0] a, input logic [3:0] b);
        alu_word = {3'b001, f, d, a, b, 12'h000};
    endfunction

    // Starts at posedge+1, returns at posedge+1 of the accepting edge.
    task automatic send(input logic [2:0] k, input logic [4:0] f, input logic [3:0] d,
                        input logic [3:0] a, input logic [3:0] b, input logic [15:0] im,
                        input logic legal, input logic [31:0] exp);
        int budget;
        kind = k; alu_func = f; rd = d; ra = a; rb = b; imm = im;
        in_valid = 1'b1;
        budget = 0;
        @(negedge clock);
        while (!in_ready && budget < 50) begin
            budget++;
            @(negedge clock);
        end
        check("accept_wait", in_ready, 1'b1);
        if (in_ready && legal) exp_q.push_back(exp);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        if (!legal) check("err_pulse", err, 1'b1);
    endtask

    task automatic send_direct(input string tag, input logic [2:0] k, input logic [4:0] f,
                               input logic [3:0] d, input logic [3:0] a, input logic [3:0] b,
                               input logic [15:0] im, input logic [31:0] exp);
        send(k, f, d, a, b, im, 1'b1, exp);
        check({tag, "_valid"}, out_valid, 1'b1);
        check(tag, out_instr, exp);
        check({tag, "_err"}, err, 1'b0);
    endtask

    task automatic drain();
        int n;
        out_ready = 1'b1;
        n = 0;
        while (level != 0 && n < 50) begin
            n++;
            @(negedge clock);
        end
        @(posedge clock);
        #1;
        check("drain_level", level, 0);
        check("drain_queue", exp_q.size(), 0);
    endtask

    initial begin
        forever begin
            @(negedge clock);
            if (!reset && out_valid && out_ready) begin
                if (exp_q.size() == 0) check("pop_unexpected", exp_q.size(), 1);
                else check("out_instr", out_instr, exp_q.pop_front());
            end
            if (!reset) check("level_max", level <= DEPTH, 1'b1);
        end
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #22 reset = 1'b0;
        @(negedge clock);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_level", level, 0);
        check("rst_err", err, 1'b0);
        check("rst_err_count", err_count, 8'd0);
        @(posedge clock);
        #1;

        // One request of each kind with the consumer always ready.
        out_ready = 1'b1;
        send_direct("alu_xor", 3'd0, 5'b10110, 4'd3, 4'd1, 4'd2, 16'hFFFF, 32'h3631_2000);
        send_direct("store", 3'd2, 5'b11111, 4'd5, 4'd2, 4'd9, 16'h0010, 32'h8152_0010);
        send_direct("load", 3'd1, 5'b00000, 4'd5, 4'd2, 4'd7, 16'h0010, 32'h8052_0010);
        send_direct("loadlit", 3'd3, 5'b00111, 4'd7, 4'd9, 4'd3, 16'hBEEF, 32'h4270_BEEF);
        send_direct("beq", 3'd5, 5'b00010, 4'd6, 4'd1, 4'd2, 16'hFFFC, 32'hA412_FFFC);
        send_direct("nop", 3'd4, 5'b00010, 4'hF, 4'hE, 4'hD, 16'h1234, 32'h0000_0000);
        send_direct("alu_01001", 3'd0, 5'b01001, 4'd1, 4'd2, 4'd3, 16'h0, 32'h2912_3000);
        send_direct("alu_10000", 3'd0, 5'b10000, 4'd4, 4'd5, 4'd6, 16'h0, 32'h3045_6000);
        drain();

        // Fill with the consumer stalled; the fifth request must wait.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            send(3'd0, 5'b00000, 4'(i), 4'd1, 4'd2, 16'h0, 1'b1, alu_word(5'b00000, 4'(i), 4'd1, 4'd2));
        fifth_done = 1'b0;
        fork
            begin
                send(3'd0, 5'b00000, 4'd4, 4'd1, 4'd2, 16'h0, 1'b1, alu_word(5'b00000, 4'd4, 4'd1, 4'd2));
                fifth_done = 1'b1;
            end
        join_none
        @(negedge clock);
        check("full_level", level, 4);
        check("full_in_ready", in_ready, 1'b0);
        @(posedge clock);
        #2 out_ready = 1'b1;
        @(posedge clock);
        #2 out_ready = 1'b0;
        check("pop_level", level, 3);
        check("pop_fifth_pending", fifth_done, 1'b0);
        check("pop_in_ready", in_ready, 1'b1);
        for (int n = 0; n < 10 && !fifth_done; n++) begin
            @(posedge clock);
            #2;
        end
        check("fifth_done", fifth_done, 1'b1);
        check("fifth_level", level, 4);
        drain();

        // Stream across pointer wrap with a toggling consumer.
        stream_done = 1'b0;
        out_ready = 1'b0;
        fork
            while (!stream_done) begin
                @(posedge clock);
                #1 out_ready = ~out_ready;
            end
        join_none
        for (int i = 0; i < 10; i++) begin
            logic [3:0] a, b;
            a = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(0, 15));
            send(3'd0, 5'b00101, 4'(i), a, b, 16'h0, 1'b1, alu_word(5'b00101, 4'(i), a, b));
        end
        stream_done = 1'b1;
        @(posedge clock);
        #2;
        drain();

        // Illegal requests.
        send(3'd0, 5'b00010, 4'd1, 4'd1, 4'd1, 16'h0, 1'b0, 32'h0);
        send(3'd6, 5'b00000, 4'd1, 4'd1, 4'd1, 16'h0, 1'b0, 32'h0);
        @(posedge clock);
        #1;
        check("ill_err_low", err, 1'b0);
        check("ill_level", level, 0);
        check("ill_count2", err_count, 8'd2);
        for (int i = 0; i < 260; i++)
            send(3'd7, 5'($urandom_range(0, 31)), 4'd0, 4'd0, 4'd0, 16'h0, 1'b0, 32'h0);
        @(posedge clock);
        #1;
        check("ill_count_sat", err_count, 8'd255);
        check("ill_level_sat", level, 0);

        // Asynchronous reset with three buffered entries.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            send(3'd3, 5'b00000, 4'(i), 4'd0, 4'd0, 16'h00AA, 1'b1, {3'b010, 5'b00010, 4'(i), 4'h0, 16'h00AA});
        check("pre_rst_level", level, 3);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_level", level, 0);
        check("mid_rst_out_instr", out_instr, 32'h0);
        check("mid_rst_in_ready", in_ready, 1'b1);
        exp_q.delete();
        @(negedge clock);
        #2 reset = 1'b0;
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        send_direct("post_rst", 3'd3, 5'b00000, 4'd1, 4'd0, 4'd0, 16'h1234, 32'h4210_1234);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
